regfile: RTL and testbench

General-purpose register file for the five-stage integer core, sitting between the decode stage and write-back. It answers the decode stage's two read requests (enable plus 5-bit address, returning 32-bit data) and accepts one write per cycle from write-back. It also keeps a per-register outstanding-write scoreboard so decode can stall on operands whose producer has not yet written back. Register 0 is hardwired to zero.

---
 rtl/regfile_if.sv | 34 +++
 rtl/regfile.sv | 100 ++++++++++
 tb/tb_regfile.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_if.sv
// Decode/write-back bus of the register file: two read ports, one write port, issue tracking.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              reg1_read_i;
    logic [ADDR_W-1:0] reg1_addr_i;
    logic [DATA_W-1:0] reg1_data_o;
    logic              reg2_read_i;
    logic [ADDR_W-1:0] reg2_addr_i;
    logic [DATA_W-1:0] reg2_data_o;
    logic              issue_i;
    logic [ADDR_W-1:0] issue_addr_i;
    logic              reg1_busy_o;
    logic              reg2_busy_o;
    logic              sb_err_o;

    modport master (
        output we_i, waddr_i, wdata_i,
        output reg1_read_i, reg1_addr_i, reg2_read_i, reg2_addr_i,
        output issue_i, issue_addr_i,
        input  reg1_data_o, reg2_data_o, reg1_busy_o, reg2_busy_o, sb_err_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i,
        input  reg1_read_i, reg1_addr_i, reg2_read_i, reg2_addr_i,
        input  issue_i, issue_addr_i,
        output reg1_data_o, reg2_data_o, reg1_busy_o, reg2_busy_o, sb_err_o
    );
endinterface

// File: rtl/regfile.sv
// Integer register file (r0 hardwired to zero) with a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic     clk,
    input  logic     rst,
    regfile_if.slave rf
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];
    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic              sb_err_q, sb_err_d;

    logic              wr_v, iss_v;
    logic [DATA_W-1:0] rd1_data, rd2_data;

    assign wr_v  = rf.we_i    && (rf.waddr_i      != '0);
    assign iss_v = rf.issue_i && (rf.issue_addr_i != '0);

    always_comb begin
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        if (wr_v) begin
            mem_d[rf.waddr_i] = rf.wdata_i;
        end
        // An issue and a write-back to the same register cancel out.
        if (!(iss_v && wr_v && (rf.issue_addr_i == rf.waddr_i))) begin
            if (iss_v) begin
                if (cnt_q[rf.issue_addr_i] == CNT_MAX) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[rf.issue_addr_i] = cnt_q[rf.issue_addr_i] + CNT_W'(1);
                end
            end
            if (wr_v) begin
                if (cnt_q[rf.waddr_i] == '0) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[rf.waddr_i] = cnt_q[rf.waddr_i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    always_comb begin
        rd1_data = '0;
        if (!rst && rf.reg1_read_i && (rf.reg1_addr_i != '0)) begin
            rd1_data = mem_q[rf.reg1_addr_i];
`ifdef REGFILE_BYPASS_EN
            if (wr_v && (rf.waddr_i == rf.reg1_addr_i)) begin
                rd1_data = rf.wdata_i;
            end
`endif
        end
    end

    always_comb begin
        rd2_data = '0;
        if (!rst && rf.reg2_read_i && (rf.reg2_addr_i != '0)) begin
            rd2_data = mem_q[rf.reg2_addr_i];
`ifdef REGFILE_BYPASS_EN
            if (wr_v && (rf.waddr_i == rf.reg2_addr_i)) begin
                rd2_data = rf.wdata_i;
            end
`endif
        end
    end

    assign rf.reg1_data_o = rd1_data;
    assign rf.reg2_data_o = rd2_data;

    // Busy looks only at registered counts, so a same-cycle write-back still reports busy.
    assign rf.reg1_busy_o = !rst && rf.reg1_read_i && (rf.reg1_addr_i != '0)
                            && (cnt_q[rf.reg1_addr_i] != '0);
    assign rf.reg2_busy_o = !rst && rf.reg2_read_i && (rf.reg2_addr_i != '0)
                            && (cnt_q[rf.reg2_addr_i] != '0);
    assign rf.sb_err_o    = !rst && sb_err_q;
endmodule

// File: tb/tb_regfile.sv
// Directed and randomized checks of regfile against a behavioural register/scoreboard model.
module tb_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_if #(.DATA_W(32), .ADDR_W(5)) rf_bus ();

    regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_bus)
    );

    // Reference state: register contents, outstanding-write count and sticky error.
    logic [31:0] m_mem [32];
    int          m_cnt [32];
    bit          m_err;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic en, input logic [4:0] a);
        if (rst || !en || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (rf_bus.we_i && rf_bus.waddr_i == a) return rf_bus.wdata_i;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic en, input logic [4:0] a);
        return !rst && en && (a != 5'd0) && (m_cnt[a] > 0);
    endfunction

    task automatic check_all();
        check("rd1",  rf_bus.reg1_data_o, exp_read(rf_bus.reg1_read_i, rf_bus.reg1_addr_i));
        check("rd2",  rf_bus.reg2_data_o, exp_read(rf_bus.reg2_read_i, rf_bus.reg2_addr_i));
        check("bsy1", {31'b0, rf_bus.reg1_busy_o}, {31'b0, exp_busy(rf_bus.reg1_read_i, rf_bus.reg1_addr_i)});
        check("bsy2", {31'b0, rf_bus.reg2_busy_o}, {31'b0, exp_busy(rf_bus.reg2_read_i, rf_bus.reg2_addr_i)});
        check("err",  {31'b0, rf_bus.sb_err_o}, {31'b0, (!rst && m_err)});
    endtask

    task automatic model_update();
        int wa, ia;
        bit wv, iv;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = 32'h0;
                m_cnt[i] = 0;
            end
            m_err = 1'b0;
            return;
        end
        wa = int'(rf_bus.waddr_i);
        ia = int'(rf_bus.issue_addr_i);
        wv = rf_bus.we_i && wa != 0;
        iv = rf_bus.issue_i && ia != 0;
        if (wv) m_mem[wa] = rf_bus.wdata_i;
        if (wv && iv && wa == ia) return;
        if (iv) begin
            if (m_cnt[ia] == 3) m_err = 1'b1;
            else m_cnt[ia] = m_cnt[ia] + 1;
        end
        if (wv) begin
            if (m_cnt[wa] == 0) m_err = 1'b1;
            else m_cnt[wa] = m_cnt[wa] - 1;
        end
    endtask

    // Apply inputs just after the falling edge, then compare all outputs against the model.
    task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                         input logic is, input logic [4:0] ia);
        rst                 = r;
        rf_bus.we_i         = w;
        rf_bus.waddr_i      = wa;
        rf_bus.wdata_i      = wd;
        rf_bus.reg1_read_i  = e1;
        rf_bus.reg1_addr_i  = a1;
        rf_bus.reg2_read_i  = e2;
        rf_bus.reg2_addr_i  = a2;
        rf_bus.issue_i      = is;
        rf_bus.issue_addr_i = ia;
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] bypass_exp;
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'hX;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
        @(negedge clk);

        // Reset: writes and issues are ignored, outputs held at zero.
        drive(1, 1, 5'd5, 32'hFFFF_FFFF, 1, 5'd5, 1, 5'd0, 1, 5'd5);
        check("rst_rd1", rf_bus.reg1_data_o, 32'h0);
        tick();
        drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        tick();
        drive(0, 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd0, 0, 5'd0);
        check("post_rst_rd1", rf_bus.reg1_data_o, 32'h0);
        check("post_rst_err", {31'b0, rf_bus.sb_err_o}, 32'h0);
        tick();

        // Write r3, then read it; a write to r0 must be discarded.
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 1, 5'd3);
        tick();
        drive(0, 1, 5'd3, 32'hDEAD_BEEF, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        tick();
        drive(0, 1, 5'd0, 32'h0000_1234, 1, 5'd3, 1, 5'd0, 0, 5'd0);
        check("r3_read", rf_bus.reg1_data_o, 32'hDEAD_BEEF);
        check("r0_read", rf_bus.reg2_data_o, 32'h0);
        tick();

        // Same-cycle write/read of r7.
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 1, 5'd7);
        tick();
`ifdef REGFILE_BYPASS_EN
        bypass_exp = 32'h55AA_55AA;
`else
        bypass_exp = 32'h0;
`endif
        drive(0, 1, 5'd7, 32'h55AA_55AA, 0, 5'd0, 1, 5'd7, 0, 5'd0);
        check("r7_same_cycle", rf_bus.reg2_data_o, bypass_exp);
        tick();
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd7, 0, 5'd0);
        check("r7_next_cycle", rf_bus.reg2_data_o, 32'h55AA_55AA);
        tick();

        // Scoreboard on r9: two issues, issue+writeback, then two write-backs.
        drive(0, 0, 5'd0, 32'h0, 1, 5'd9, 0, 5'd0, 1, 5'd9);
        check("r9_busy_before", {31'b0, rf_bus.reg1_busy_o}, 32'h0);
        tick();
        drive(0, 0, 5'd0, 32'h0, 1, 5'd9, 0, 5'd0, 1, 5'd9);
        check("r9_busy_1", {31'b0, rf_bus.reg1_busy_o}, 32'h1);
        tick();
        drive(0, 1, 5'd9, 32'h0000_0099, 1, 5'd9, 0, 5'd0, 1, 5'd9);
        check("r9_busy_2", {31'b0, rf_bus.reg1_busy_o}, 32'h1);
        tick();
        drive(0, 1, 5'd9, 32'h0000_0999, 1, 5'd9, 1, 5'd9, 0, 5'd0);
        check("r9_busy_same", {31'b0, rf_bus.reg1_busy_o}, 32'h1);
        tick();
        drive(0, 1, 5'd9, 32'h0000_9999, 0, 5'd9, 1, 5'd9, 0, 5'd0);
        check("r9_dis_data", rf_bus.reg1_data_o, 32'h0);
        check("r9_dis_busy", {31'b0, rf_bus.reg1_busy_o}, 32'h0);
        check("r9_busy_after_wb1", {31'b0, rf_bus.reg2_busy_o}, 32'h1);
        tick();
        drive(0, 0, 5'd0, 32'h0, 1, 5'd9, 0, 5'd0, 0, 5'd0);
        check("r9_busy_clear", {31'b0, rf_bus.reg1_busy_o}, 32'h0);
        check("r9_no_err", {31'b0, rf_bus.sb_err_o}, 32'h0);
        tick();

        // Overflow r4: fourth issue sets the sticky error.
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 5'd0, 32'h0, 1, 5'd4, 0, 5'd0, 1, 5'd4);
            check("r4_err_pre", {31'b0, rf_bus.sb_err_o}, 32'h0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 5'd0, 32'h0, 1, 5'd4, 0, 5'd0, 0, 5'd0);
            check("r4_err_sticky", {31'b0, rf_bus.sb_err_o}, 32'h1);
            tick();
        end
        drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        tick();
        drive(0, 0, 5'd0, 32'h0, 1, 5'd4, 0, 5'd0, 0, 5'd0);
        check("r4_err_cleared", {31'b0, rf_bus.sb_err_o}, 32'h0);
        check("r4_busy_cleared", {31'b0, rf_bus.reg1_busy_o}, 32'h0);
        tick();

        // Randomized traffic over a small address window so counters saturate and drain.
        for (int n = 0; n < 400; n++) begin
            logic r;
            r = ($urandom_range(0, 59) == 0);
            drive(r, 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
